// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch: owns the PC, issues one fetch at a time, and hands PC/instruction pairs to decode.
// Optional misaligned-PC fault reporting when YSYX_24100006_IFU_MISALIGN_EN is defined.
module ysyx_24100006_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
`ifdef YSYX_24100006_IFU_MISALIGN_EN
  output logic              out_fault,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0]   out_inst_q, out_inst_d;
  logic                enter_req;
  logic                req_fire;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
  logic                fault_q, fault_d;
`endif

  assign req_fire = (state_q == REQ) && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    enter_req  = 1'b0;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      IDLE: enter_req = 1'b1;
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (req_fire) state_d = DRAIN;
          else          enter_req = 1'b1;
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) enter_req = 1'b1;
          else                state_d = DRAIN;
        end else if (imem_rsp_valid) begin
          out_inst_d = imem_rsp_inst;
          out_pc_d   = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || out_ready) begin
          pc_d      = redirect_valid ? redirect_pc : pc_q + ADDR_W'(4);
          enter_req = 1'b1;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
          fault_d   = 1'b0;
`endif
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_d = redirect_pc;
        // A squashed response arriving with a new redirect still retires the drain.
        if (imem_rsp_valid) enter_req = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (enter_req) begin
      state_d = REQ;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
      if (pc_d[1:0] != 2'b00) begin
        state_d    = HOLD;
        fault_d    = 1'b1;
        out_inst_d = INST_W'(32'h0000_0013);
        out_pc_d   = pc_d;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      out_pc_q   <= '0;
      out_inst_q <= '0;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = pc_q;
  assign out_valid      = (state_q == HOLD);
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
`ifdef YSYX_24100006_IFU_MISALIGN_EN
  assign out_fault      = fault_q;
`endif

endmodule
